// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - bin classes, pilot values and frame geometry helpers for the subcarrier framer
package ofdm_pkg;

  typedef enum logic [1:0] {
    BIN_NULL  = 2'd0,
    BIN_PILOT = 2'd1,
    BIN_DATA  = 2'd2
  } bin_class_e;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_PAD   = 2'd1,
    ST_DRAIN = 2'd2
  } framer_state_e;

  localparam logic [7:0] PILOT_POS = 8'h11;
  localparam logic [7:0] PILOT_NEG = 8'hFF;

  // DC and the guard band straddling Nyquist win over the pilot lattice
  function automatic bin_class_e bin_class(input int k, input int n_sub, input int ng_half,
                                           input int pilot_stride, input int pilot_offset);
    bin_class_e cls;
    if (k == 0 || (k >= n_sub / 2 - ng_half && k < n_sub / 2 + ng_half)) begin
      cls = BIN_NULL;
    end else if (k % pilot_stride == pilot_offset) begin
      cls = BIN_PILOT;
    end else begin
      cls = BIN_DATA;
    end
    return cls;
  endfunction

  function automatic int n_data(input int n_sub, input int ng_half,
                                input int pilot_stride, input int pilot_offset);
    int cnt;
    cnt = 0;
    for (int k = 0; k < n_sub; k++) begin
      if (bin_class(k, n_sub, ng_half, pilot_stride, pilot_offset) == BIN_DATA) begin
        cnt++;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ofdm_subcarrier_framer_if.sv
// rtl/ofdm_subcarrier_framer_if.sv - symbol-in and bin-out handshake bundle of the framer
interface ofdm_subcarrier_framer_if;

  logic [7:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       flush;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_first;
  logic       out_last;

  modport master (
    output sym_in, sym_valid, flush, out_ready,
    input  sym_ready, out_data, out_valid, out_first, out_last
  );

  modport slave (
    input  sym_in, sym_valid, flush, out_ready,
    output sym_ready, out_data, out_valid, out_first, out_last
  );

endinterface

// File: rtl/ofdm_bin_classifier.sv
// rtl/ofdm_bin_classifier.sv - combinational bin index to bin class decode
module ofdm_bin_classifier
  import ofdm_pkg::*;
#(
  parameter int N_SUB        = 16,
  parameter int NG_HALF      = 2,
  parameter int PILOT_STRIDE = 4,
  parameter int PILOT_OFFSET = 2,
  localparam int BIN_W       = $clog2(N_SUB)
) (
  input  logic [BIN_W-1:0] bin_idx,
  output bin_class_e       bin_cls
);

  assign bin_cls = bin_class(int'(bin_idx), N_SUB, NG_HALF, PILOT_STRIDE, PILOT_OFFSET);

endmodule

// File: rtl/ofdm_subcarrier_framer.sv
// rtl/ofdm_subcarrier_framer.sv - gathers mapped symbols and streams one IFFT frame with pilots and nulls
module ofdm_subcarrier_framer
  import ofdm_pkg::*;
#(
  parameter int N_SUB        = 16,
  parameter int NG_HALF      = 2,
  parameter int PILOT_STRIDE = 4,
  parameter int PILOT_OFFSET = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ofdm_subcarrier_framer_if.slave  sif,
  output logic [7:0]               frame_count,
  output logic                     busy
);

  localparam int N_DATA = n_data(N_SUB, NG_HALF, PILOT_STRIDE, PILOT_OFFSET);
  localparam int BIN_W  = $clog2(N_SUB);
  localparam int CNT_W  = $clog2(N_DATA + 1);
  localparam logic [CNT_W-1:0] LAST_WR  = CNT_W'(N_DATA - 1);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_SUB - 1);

  generate
    if (N_DATA < 1) begin : g_bad_geometry
      $error("ofdm_subcarrier_framer: subcarrier geometry leaves no data bins");
    end
  endgenerate

  framer_state_e    state_q, state_d;
  logic [7:0]       sym_buf_q [N_DATA];
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q, rd_next, ld_rd;
  logic [BIN_W-1:0] bin_cnt_q, ld_bin;
  logic             pilot_pol_q, cur_data_q;
  logic [7:0]       out_data_q, rd_word, ld_word, wr_data;
  logic             out_valid_q, out_first_q, out_last_q;
  logic [7:0]       frame_count_q;
  logic             accept, fill_done, pad_done, beat, frame_end;
  logic             load_first, load_next, wr_en;
  bin_class_e       ld_cls;

  always_comb begin
    accept     = (state_q == ST_FILL) && sif.sym_valid;
    fill_done  = accept && (wr_cnt_q == LAST_WR);
    pad_done   = (state_q == ST_PAD) && (wr_cnt_q == LAST_WR);
    beat       = (state_q == ST_DRAIN) && out_valid_q && sif.out_ready;
    frame_end  = beat && (bin_cnt_q == LAST_BIN);
    load_first = fill_done || pad_done;
    load_next  = beat && !frame_end;
    wr_en      = accept || (state_q == ST_PAD);
    wr_data    = accept ? sif.sym_in : 8'h00;

    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        // a symbol taken alongside flush is stored first; completing the frame skips padding
        if (fill_done) begin
          state_d = ST_DRAIN;
        end else if (sif.flush && (accept || wr_cnt_q != '0)) begin
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (pad_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (frame_end) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // the output register always holds the bin being offered; the next bin is prepared on each beat
  assign rd_next = rd_cnt_q + CNT_W'(cur_data_q);
  assign ld_bin  = load_first ? '0 : bin_cnt_q + 1'b1;
  assign ld_rd   = load_first ? '0 : rd_next;

  ofdm_bin_classifier #(
    .N_SUB        (N_SUB),
    .NG_HALF      (NG_HALF),
    .PILOT_STRIDE (PILOT_STRIDE),
    .PILOT_OFFSET (PILOT_OFFSET)
  ) u_classifier (
    .bin_idx (ld_bin),
    .bin_cls (ld_cls)
  );

  always_comb begin
    rd_word = 8'h00;
    for (int i = 0; i < N_DATA; i++) begin
      if (ld_rd == CNT_W'(i)) rd_word = sym_buf_q[i];
    end
    case (ld_cls)
      BIN_PILOT: ld_word = pilot_pol_q ? PILOT_NEG : PILOT_POS;
      BIN_DATA:  ld_word = rd_word;
      default:   ld_word = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DATA; i++) sym_buf_q[i] <= 8'h00;
    end else if (wr_en) begin
      for (int i = 0; i < N_DATA; i++) begin
        if (wr_cnt_q == CNT_W'(i)) sym_buf_q[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      bin_cnt_q     <= '0;
      pilot_pol_q   <= 1'b0;
      cur_data_q    <= 1'b0;
      out_data_q    <= 8'h00;
      out_valid_q   <= 1'b0;
      out_first_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_count_q <= 8'h00;
    end else begin
      if (load_first) begin
        wr_cnt_q <= '0;
      end else if (wr_en) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end

      if (load_first || load_next) begin
        bin_cnt_q   <= ld_bin;
        rd_cnt_q    <= ld_rd;
        cur_data_q  <= (ld_cls == BIN_DATA);
        out_data_q  <= ld_word;
        out_valid_q <= 1'b1;
        out_first_q <= load_first;
        out_last_q  <= (ld_bin == LAST_BIN);
      end else if (frame_end) begin
        bin_cnt_q     <= '0;
        rd_cnt_q      <= '0;
        cur_data_q    <= 1'b0;
        out_data_q    <= 8'h00;
        out_valid_q   <= 1'b0;
        out_first_q   <= 1'b0;
        out_last_q    <= 1'b0;
        frame_count_q <= frame_count_q + 8'd1;
        pilot_pol_q   <= ~pilot_pol_q;
      end
    end
  end

  assign sif.sym_ready = (state_q == ST_FILL);
  assign sif.out_data  = out_data_q;
  assign sif.out_valid = out_valid_q;
  assign sif.out_first = out_first_q;
  assign sif.out_last  = out_last_q;
  assign frame_count   = frame_count_q;
  assign busy          = (state_q == ST_DRAIN) || ((state_q == ST_FILL) && (wr_cnt_q != '0));

endmodule

// File: doc/ofdm_subcarrier_framer.md
Name: ofdm_subcarrier_framer

Overview:
Sits directly downstream of the QPSK/16-QAM symbol mapper and upstream of the IFFT. It collects mapped constellation symbols, places them onto data subcarriers, and inserts pilots and null bins (DC and band-edge guards). It then streams one complete N_SUB-bin frequency-domain frame, in natural IFFT bin order, with a valid/ready handshake on both sides.
- Symbol format on both sides: 8 bits. I = [3:0], Q = [7:4], each 4-bit two's complement.

Parameters:
- N_SUB, 16: subcarriers per frame. Power of two, 8..64.
- NG_HALF, 2: null bins each side of Nyquist. Bins N_SUB/2-NG_HALF .. N_SUB/2+NG_HALF-1 are null.
- PILOT_STRIDE, 4: pilot spacing in bins.
- PILOT_OFFSET, 2: a bin k is a pilot when k mod PILOT_STRIDE == PILOT_OFFSET and k is not null.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- sym_in  in  8  mapped symbol from the mapper.
- sym_valid  in  1  sym_in valid.
- sym_ready  out  1  framer can accept a symbol.
- flush  in  1  one-cycle pulse; pad a partially filled frame with zero symbols and emit it.
- out_data  out  8  bin value to the IFFT.
- out_valid  out  1  out_data valid.
- out_ready  in  1  IFFT accepts.
- out_first  out  1  current beat is bin 0.
- out_last  out  1  current beat is bin N_SUB-1.
- frame_count  out  8  frames emitted, wraps at 255→0.
- busy  out  1  high in DRAIN, or in FILL with at least one data bin filled.

Behaviour:
- Bin classes, in priority order: NULL (bin 0 and the guard range), then PILOT, then DATA.
- N_DATA = number of DATA bins. With defaults N_DATA = 8: data bins 1,3,4,5,11,12,13,15; pilot bins 2,10,14; null bins 0,6,7,8,9.
- Storage: N_DATA x 8 register buffer, write pointer wr_cnt, read pointer rd_cnt, bin counter bin_cnt.
- FSM states: FILL, PAD, DRAIN.
- Reset state: FILL; all counters 0; pilot_pol = 0. Outputs: out_valid=0, out_first=0, out_last=0, out_data=0, frame_count=0, busy=0, sym_ready=1.
- FILL:
  - sym_ready=1.
  - On sym_valid && sym_ready: buf[wr_cnt] <= sym_in; wr_cnt++.
  - When the accepted symbol is number N_DATA: next state DRAIN, wr_cnt <= 0.
  - flush with wr_cnt>0, or flush together with an accepted symbol: go to PAD. A symbol accepted in the same cycle as flush is stored first. If that symbol completes the frame, go directly to DRAIN.
  - flush with wr_cnt==0 and no accepted symbol: ignored.
- PAD:
  - sym_ready=0.
  - Writes 8'h00 to buf[wr_cnt] one entry per cycle until the buffer is full, then DRAIN.
- DRAIN:
  - sym_ready=0; flush ignored.
  - out_valid=1. out_data is the registered value of bin bin_cnt:
    - NULL → 8'h00.
    - PILOT → 8'h11 (I=+1, Q=+1) when pilot_pol=0; 8'hFF (I=-1, Q=-1) when pilot_pol=1.
    - DATA → buf[rd_cnt].
  - Beat advances only on out_valid && out_ready. rd_cnt increments only when a DATA beat completes.
  - While out_ready=0, out_data, out_first and out_last hold stable.
- Latency: the symbol completing a frame is accepted at cycle t; out_valid=1 with bin 0 at cycle t+1. In PAD, out_valid rises the cycle after the last pad write.
- Frame end: on the bin N_SUB-1 handshake: out_valid=0 next cycle, state FILL, frame_count++, pilot_pol toggles, bin_cnt=0, rd_cnt=0. sym_ready returns to 1 in that same next cycle.
- Minimum frame period: N_DATA + N_SUB cycles with continuous valid/ready.
- Reset mid-operation: the partial frame is discarded, outputs go to reset values immediately, no partial frame is emitted.
- Counter widths: $clog2(N_SUB) bits for bin_cnt; $clog2(N_DATA+1) bits for wr_cnt and rd_cnt.
- Elaboration check: N_DATA >= 1.

Decomposition:
Shared package ofdm_pkg holds:
- bin-class enum (BIN_NULL, BIN_PILOT, BIN_DATA).
- PILOT_POS = 8'h11 and PILOT_NEG = 8'hFF.
- function bin_class(k, N_SUB, NG_HALF, PILOT_STRIDE, PILOT_OFFSET).
- function n_data(...) returning N_DATA.

One natural sub-module: ofdm_bin_classifier, combinational, bin index in, class out. Used in DRAIN.

Test Plan:
- Feed A1..A8 back-to-back with out_ready=1 → bins 0..15 = 00,A1,11,A2,A3,A4,00,00,00,00,11,A5,A6,A7,11,A8. out_first on beat 0, out_last on beat 15, frame_count=1.
- Send a second frame B1..B8 → pilot bins 2,10,14 = FF. Data in order. frame_count=2.
- Send C1..C3, then pulse flush → bins 1,3,4 = C1,C2,C3. Remaining data bins 00. Pilots 11 (frame_count was even).
- During DRAIN hold out_ready=0 for 5 cycles at bin 3 → out_data holds A2, sym_ready=0. Stream resumes intact.
- Assert rst_n=0 mid-DRAIN at bin 7, release, send D1..D8 → only the D frame emitted, pilots 11, frame_count=1.
- flush with the buffer empty → no output, busy stays 0. flush together with the 8th symbol → normal frame, no extra padding.
